// File: rtl/misaligned_load_sequencer_if.sv
// Load request / data memory / writeback bundle for the
// misaligned load sequencer.
interface misaligned_load_sequencer_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 20,
  parameter int LOG2_NUM_BYTES = 2
);
  logic                      load_req;
  logic                      load_ready;
  logic [ADDRESS_BITS-1:0]   load_address;
  logic [LOG2_NUM_BYTES-1:0] log2_bytes;
  logic                      unsigned_load;
  logic                      mem_read;
  logic [ADDRESS_BITS-1:0]   mem_address;
  logic                      mem_ready;
  logic                      mem_valid;
  logic [DATA_WIDTH-1:0]     mem_data_in;
  logic                      load_valid;
  logic [DATA_WIDTH-1:0]     load_data;
  logic                      load_error;

  modport master (
    output load_req, load_address, log2_bytes,
    output unsigned_load,
    output mem_ready, mem_valid, mem_data_in,
    input  load_ready, mem_read, mem_address,
    input  load_valid, load_data, load_error
  );

  modport slave (
    input  load_req, load_address, log2_bytes,
    input  unsigned_load,
    input  mem_ready, mem_valid, mem_data_in,
    output load_ready, mem_read, mem_address,
    output load_valid, load_data, load_error
  );
endinterface

// File: rtl/misaligned_load_sequencer.sv
// Splits a load into one or two aligned word reads,
// merges them, then shifts and sign/zero-extends.
module misaligned_load_sequencer #(
  parameter int CORE            = 0,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_BITS    = 20,
  parameter int NUM_BYTES       = DATA_WIDTH / 8,
  parameter int LOG2_NUM_BYTES  = $clog2(NUM_BYTES),
  parameter int SCAN_CYCLES_MIN = 0,
  parameter int SCAN_CYCLES_MAX = 1000
) (
  input logic clock,
  input logic reset,
  input logic scan,
  misaligned_load_sequencer_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int AB = ADDRESS_BITS;
  localparam int LB = LOG2_NUM_BYTES;
  localparam int SW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP
  } state_t;

  state_t state_q, state_d;

  logic [AB-1:0]  addr_q;
  logic [LB-1:0]  size_q;
  logic           uns_q;
  logic           cross_q;
  logic           err_q;
  logic [DW-1:0]  lo_q;
  logic [DW-1:0]  hi_q;
  logic [31:0]    cycle_q;

  int             req_bytes;
  logic           accept;
  logic           illegal;
  logic           crosses;
  logic [AB-1:0]  aligned;
  logic [2*DW-1:0] pair;
  logic [DW-1:0]  shifted;
  logic [DW-1:0]  mask;
  logic [DW-1:0]  ext;
  logic [SW:0]    nbits;
  logic [SW:0]    top;
  logic           sbit;

  always_comb begin
    req_bytes = 1 << int'(bus.log2_bytes);
    illegal   = req_bytes > NUM_BYTES;
    crosses   = int'(bus.load_address[LB-1:0])
              + req_bytes > NUM_BYTES;
    accept    = (state_q == IDLE) && bus.load_req;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (accept && !illegal) state_d = ISSUE0;
      ISSUE0:
        if (bus.mem_ready) state_d = WAIT0;
      WAIT0:
        if (bus.mem_valid)
          state_d = cross_q ? ISSUE1 : RESP;
      ISSUE1:
        if (bus.mem_ready) state_d = WAIT1;
      WAIT1:
        if (bus.mem_valid) state_d = RESP;
      RESP:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      cross_q <= 1'b0;
      err_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      cycle_q <= '0;
    end else begin
      err_q   <= accept & illegal;
      cycle_q <= cycle_q + 32'd1;
      if (accept) begin
        addr_q  <= bus.load_address;
        size_q  <= bus.log2_bytes;
        uns_q   <= bus.unsigned_load;
        cross_q <= crosses;
        lo_q    <= '0;
        hi_q    <= '0;
      end
      if (state_q == WAIT0 && bus.mem_valid)
        lo_q <= bus.mem_data_in;
      if (state_q == WAIT1 && bus.mem_valid)
        hi_q <= bus.mem_data_in;
    end
  end

  // Extension point is the top bit of the access;
  // everything above it is filled with sign or zero.
  always_comb begin
    mask    = '0;
    pair    = {hi_q, lo_q} >> {addr_q[LB-1:0], 3'b000};
    shifted = pair[DW-1:0];
    nbits   = (SW+1)'(8) << size_q;
    top     = nbits - (SW+1)'(1);
    sbit    = ~uns_q & shifted[top[SW-1:0]];
    for (int i = 0; i < DW; i++)
      mask[i] = i < int'(nbits);
    ext = (shifted & mask) | ({DW{sbit}} & ~mask);
  end

  assign aligned = {addr_q[AB-1:LB], LB'(0)};

  assign bus.load_ready  = (state_q == IDLE) & ~reset;
  assign bus.mem_read    = (state_q == ISSUE0)
                         | (state_q == ISSUE1);
  assign bus.mem_address =
    (state_q == ISSUE0) ? aligned :
    (state_q == ISSUE1) ? aligned + AB'(NUM_BYTES) :
    '0;
  assign bus.load_valid  = state_q == RESP;
  assign bus.load_data   = (state_q == RESP) ? ext : '0;
  assign bus.load_error  = err_q;

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (scan
        && longint'(cycle_q) >= longint'(SCAN_CYCLES_MIN)
        && longint'(cycle_q) <= longint'(SCAN_CYCLES_MAX))
      $display(
        "core=%0d cyc=%0d st=%s adr=%h rd=%b madr=%h rdy=%b vld=%b din=%h ld=%h",
        CORE, cycle_q, state_q.name(), addr_q,
        bus.mem_read, bus.mem_address, bus.mem_ready,
        bus.mem_valid, bus.mem_data_in, bus.load_data);
  end
`endif
endmodule

// File: tb/tb_misaligned_load_sequencer.sv
// Randomized bench for misaligned_load_sequencer with a
// byte-level memory reference model.
module tb_misaligned_load_sequencer;
  logic clock;
  logic reset;
  logic scan;

  misaligned_load_sequencer_if #(
    .DATA_WIDTH(32), .ADDRESS_BITS(20), .LOG2_NUM_BYTES(2)
  ) bus ();

  misaligned_load_sequencer #(
    .CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20)
  ) dut (
    .clock(clock),
    .reset(reset),
    .scan (scan),
    .bus  (bus.slave)
  );

  int n_chk;
  int n_fail;
  logic [31:0] mem [int];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [19:0] a);
    int idx;
    idx = int'(a >> 2);
    if (mem.exists(idx)) return mem[idx];
    return (32'(idx) * 32'h9E3779B1) ^ 32'hA5C30F1E;
  endfunction

  // Reference: gather the accessed bytes one by one, then extend.
  function automatic logic [31:0] model(input logic [19:0] a,
                                        input logic [1:0] sz,
                                        input logic u);
    int n;
    logic [63:0] v;
    logic [19:0] b;
    logic [31:0] w;
    n = 1 << sz;
    v = '0;
    for (int k = 0; k < n; k++) begin
      b = a + 20'(k);
      w = word_at({b[19:2], 2'b00});
      v |= 64'((w >> (8 * b[1:0])) & 32'hFF) << (8 * k);
    end
    if (!u && v[8*n-1]) v |= {64{1'b1}} << (8 * n);
    return v[31:0];
  endfunction

  task automatic noise(input bit rnd);
    if (rnd) begin
      bus.load_req      = 1'($urandom_range(0, 1));
      bus.load_address  = 20'($urandom);
      bus.log2_bytes    = 2'($urandom);
      bus.unsigned_load = 1'($urandom);
    end
  endtask

  task automatic do_load(input logic [19:0] a,
                         input logic [1:0] sz,
                         input logic u,
                         input bit rnd,
                         input int stall0,
                         output logic [31:0] got,
                         output int lat);
    logic [31:0] exp;
    logic [19:0] rd [2];
    int nrd, cyc, w, stall, d;
    bit ill, cr;
    ill   = (1 << sz) > 4;
    cr    = (int'(a[1:0]) + (1 << sz)) > 4;
    rd[0] = {a[19:2], 2'b00};
    rd[1] = rd[0] + 20'd4;
    nrd   = cr ? 2 : 1;
    exp   = model(a, sz, u);
    got   = '0;
    lat   = 0;
    @(negedge clock);
    chk("idle_ready", 32'(bus.load_ready), 1);
    bus.load_req      = 1'b1;
    bus.load_address  = a;
    bus.log2_bytes    = sz;
    bus.unsigned_load = u;
    cyc = 0;
    @(negedge clock);
    cyc = 1;
    bus.load_req = 1'b0;
    if (ill) begin
      chk("err_pulse", 32'(bus.load_error), 1);
      chk("err_nord", 32'(bus.mem_read), 0);
      @(negedge clock);
      chk("err_clr", 32'(bus.load_error), 0);
      chk("err_nord2", 32'(bus.mem_read), 0);
      chk("err_lv", 32'(bus.load_valid), 0);
      return;
    end
    chk("no_err", 32'(bus.load_error), 0);
    for (int r = 0; r < nrd; r++) begin
      if (r == 0 && stall0 >= 0) stall = stall0;
      else stall = rnd ? int'($urandom_range(0, 4)) : 0;
      w = 0;
      while (1) begin
        chk("mrd", 32'(bus.mem_read), 1);
        chk("madr", 32'(bus.mem_address), 32'(rd[r]));
        chk("busy_lv", 32'(bus.load_valid), 0);
        noise(rnd);
        bus.mem_ready   = (w >= stall);
        bus.mem_valid   = rnd && ($urandom_range(0, 3) == 0);
        bus.mem_data_in = $urandom;
        @(negedge clock);
        cyc++;
        if (w >= stall) break;
        w++;
      end
      bus.mem_ready = 1'b0;
      bus.mem_valid = 1'b0;
      d = rnd ? int'($urandom_range(0, 2)) : 0;
      repeat (d) begin
        chk("wait_nord", 32'(bus.mem_read), 0);
        chk("wait_lv", 32'(bus.load_valid), 0);
        noise(rnd);
        @(negedge clock);
        cyc++;
      end
      chk("wait_nord", 32'(bus.mem_read), 0);
      noise(rnd);
      bus.mem_valid   = 1'b1;
      bus.mem_data_in = word_at(rd[r]);
      @(negedge clock);
      cyc++;
      bus.mem_valid   = 1'b0;
      bus.mem_data_in = $urandom;
    end
    bus.load_req = 1'b0;
    chk("lv", 32'(bus.load_valid), 1);
    chk("ld_data", bus.load_data, exp);
    chk("resp_ready", 32'(bus.load_ready), 0);
    got = bus.load_data;
    lat = cyc;
    @(negedge clock);
    chk("lv_pulse", 32'(bus.load_valid), 0);
    chk("ld_zero", bus.load_data, 0);
    if (rnd && $urandom_range(0, 1) == 1) begin
      bus.mem_valid = 1'b1;
      @(negedge clock);
      bus.mem_valid = 1'b0;
      chk("stray_lv", 32'(bus.load_valid), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    int lat;
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    scan   = 1'b0;
    bus.load_req      = 1'b0;
    bus.load_address  = '0;
    bus.log2_bytes    = '0;
    bus.unsigned_load = 1'b0;
    bus.mem_ready     = 1'b0;
    bus.mem_valid     = 1'b0;
    bus.mem_data_in   = '0;
    repeat (2) @(negedge clock);
    chk("rst_ready", 32'(bus.load_ready), 0);
    chk("rst_mrd", 32'(bus.mem_read), 0);
    chk("rst_lv", 32'(bus.load_valid), 0);
    chk("rst_data", bus.load_data, 0);
    chk("rst_err", 32'(bus.load_error), 0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.load_ready), 1);

    mem[32'h4] = 32'hDEADBEEF;
    do_load(20'h00010, 2'd2, 1'b0, 1'b0, -1, got, lat);
    chk("t1_lw", got, 32'hDEADBEEF);
    chk("t1_lat", 32'(lat), 3);

    mem[32'h4] = 32'h80112233;
    do_load(20'h00013, 2'd0, 1'b0, 1'b0, -1, got, lat);
    chk("t2_lb", got, 32'hFFFFFF80);
    do_load(20'h00013, 2'd0, 1'b1, 1'b0, -1, got, lat);
    chk("t2_lbu", got, 32'h00000080);

    mem[32'h1] = 32'h44332211;
    mem[32'h2] = 32'h88776655;
    do_load(20'h00006, 2'd2, 1'b0, 1'b0, -1, got, lat);
    chk("t3_lw", got, 32'h66554433);
    chk("t3_lat", 32'(lat), 5);

    mem[32'h2] = 32'h887766F5;
    do_load(20'h00007, 2'd1, 1'b0, 1'b0, -1, got, lat);
    chk("t4_lh", got, 32'hFFFFF544);
    do_load(20'h00007, 2'd1, 1'b1, 1'b0, -1, got, lat);
    chk("t4_lhu", got, 32'h0000F544);

    mem[32'h3FFFF] = 32'hCAFEBABE;
    mem[32'h0]     = 32'h12345678;
    do_load(20'hFFFFE, 2'd2, 1'b0, 1'b0, -1, got, lat);
    chk("t5_wrap", got, 32'h5678CAFE);
    do_load(20'h00010, 2'd3, 1'b0, 1'b0, -1, got, lat);

    do_load(20'h00010, 2'd2, 1'b0, 1'b0, 5, got, lat);
    chk("t6_stall", got, 32'h80112233);
    chk("t6_lat", 32'(lat), 8);

    // Reset while waiting on the second word.
    @(negedge clock);
    bus.load_req      = 1'b1;
    bus.load_address  = 20'h00006;
    bus.log2_bytes    = 2'd2;
    bus.unsigned_load = 1'b0;
    @(negedge clock);
    bus.load_req  = 1'b0;
    bus.mem_ready = 1'b1;
    @(negedge clock);
    bus.mem_ready   = 1'b0;
    bus.mem_valid   = 1'b1;
    bus.mem_data_in = word_at(20'h00004);
    @(negedge clock);
    bus.mem_valid = 1'b0;
    chk("r_madr", 32'(bus.mem_address), 32'h8);
    bus.mem_ready = 1'b1;
    @(negedge clock);
    bus.mem_ready = 1'b0;
    chk("r_w1", 32'(bus.mem_read), 0);
    reset = 1'b1;
    #1;
    chk("r_ready", 32'(bus.load_ready), 0);
    chk("r_lv", 32'(bus.load_valid), 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("r_idle", 32'(bus.load_ready), 1);
    bus.mem_valid   = 1'b1;
    bus.mem_data_in = word_at(20'h00008);
    @(negedge clock);
    bus.mem_valid = 1'b0;
    repeat (3) begin
      chk("r_late_lv", 32'(bus.load_valid), 0);
      chk("r_late_ready", 32'(bus.load_ready), 1);
      @(negedge clock);
    end

    for (int i = 0; i < 150; i++) begin
      logic [19:0] a;
      a = 20'($urandom);
      if (i % 10 == 0) a = 20'hFFFFC | 20'($urandom_range(0, 3));
      do_load(a, 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'b1, -1, got, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
